// File: rtl/cache_types.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package cache_types;

    localparam int S_INDEX    = 3;
    localparam int S_OFFSET   = 5;
    localparam int TAG_W      = 32 - S_INDEX - S_OFFSET;
    localparam int LINE_W     = 256;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int NUM_SETS   = 1 << S_INDEX;
    localparam int WORD_W     = S_OFFSET - 2;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } dcache_state_t;

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [S_INDEX-1:0] index);
        return {tag, index, {S_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Per-set line storage: byte-granular write enable, fill-or-store data mux, combinational read.
module dcache_array
    import cache_types::*;
(
    input  logic                  clk,
    input  logic [S_INDEX-1:0]    index,
    input  logic [LINE_BYTES-1:0] wen,
    input  logic                  fill,
    input  logic [LINE_W-1:0]     fill_data,
    input  logic [31:0]           store_data,
    output logic [LINE_W-1:0]     line
);

    logic [LINE_W-1:0] lines [NUM_SETS];
    logic [LINE_W-1:0] wdata;

    // A store word is replicated across the line; wen picks the lanes it lands in.
    assign wdata = fill ? fill_data : {(LINE_W / 32){store_data}};

    // NOTE: line storage has no reset; valid bits gate its use, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (wen[b]) lines[index][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    assign line = lines[index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a 256-bit line-burst backing port.
module data_cache
    import cache_types::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               data_read,
    input  logic               data_write,
    input  logic [31:0]        data_addr,
    input  logic [3:0]         data_mbe,
    input  logic [31:0]        data_wdata,
    output logic [31:0]        data_rdata,
    output logic               data_resp,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [31:0]        pmem_address,
    output logic [LINE_W-1:0]  pmem_wdata,
    input  logic [LINE_W-1:0]  pmem_rdata,
    input  logic               pmem_resp
);

    logic [TAG_W-1:0]      tag;
    logic [S_INDEX-1:0]    index;
    logic [WORD_W-1:0]     word;
    dcache_state_t         state;
    logic [NUM_SETS-1:0]   valid;
    logic [NUM_SETS-1:0]   dirty;
    logic [TAG_W-1:0]      tags [NUM_SETS];
    logic [LINE_W-1:0]     line;
    logic [LINE_BYTES-1:0] wen;
    logic                  req;
    logic                  hit;
    logic                  store_hit;
    logic                  fill_done;

    assign tag   = data_addr[31:32-TAG_W];
    assign index = data_addr[S_OFFSET +: S_INDEX];
    assign word  = data_addr[2 +: WORD_W];

    assign req       = data_read | data_write;
    assign hit       = valid[index] && (tags[index] == tag);
    assign store_hit = (state == IDLE) && data_write && hit;
    assign fill_done = (state == FILL) && pmem_resp;
    assign wen       = fill_done ? '1 :
                       store_hit ? ({28'b0, data_mbe} << {word, 2'b00}) : '0;

    dcache_array u_array (
        .clk        (clk),
        .index      (index),
        .wen        (wen),
        .fill       (fill_done),
        .fill_data  (pmem_rdata),
        .store_data (data_wdata),
        .line       (line)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit)
                        state <= (valid[index] && dirty[index]) ? WRITEBACK : FILL;
                    else if (store_hit && (|data_mbe))
                        dirty[index] <= 1'b1;
                end
                WRITEBACK: if (pmem_resp) state <= FILL;
                FILL: begin
                    if (pmem_resp) begin
                        valid[index] <= 1'b1;
                        dirty[index] <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) tags[index] <= tag;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        data_resp    = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        case (state)
            IDLE:      data_resp = req && hit;
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = line_addr(tags[index], index);
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = line_addr(tag, index);
            end
            default: ;
        endcase
    end

    assign pmem_wdata = line;
    assign data_rdata = line[{word, 5'b00000} +: 32];

    // Requester protocol checks; simulation only.
    rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(data_read && data_write)) else $error("data_read and data_write asserted together");
    addr_stable: assert property (@(posedge clk) disable iff (rst)
        (state != IDLE && req) |-> $stable(data_addr)) else $error("data_addr changed during a miss");
    addr_aligned: assert property (@(posedge clk) disable iff (rst)
        req |-> (data_addr[1:0] == 2'b00)) else $error("data_addr not word aligned");

endmodule
